// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - truth-table capture of an external 7-input function
// Sweeps x over 0..127, samples f_in after SETTLE cycles per vector, and counts mismatches against exp_tt.
module tt_sweep_capture #(
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] exp_tt,
   input  logic         f_in,
   output logic [6:0]   x,
   output logic         busy,
   output logic [127:0] tt_out,
   output logic         tt_valid,
   input  logic         tt_ready,
   output logic [7:0]   mism_cnt,
   output logic [6:0]   first_mism,
   output logic         mism_any
);

   typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [7:0] MISM_MAX    = 8'd128;

   state_t         state_q, state_d;
   logic [6:0]     x_q;
   logic [3:0]     cnt_q;
   logic [127:0]   exp_q;
   logic [127:0]   tt_q;
   logic [7:0]     mism_q;
   logic [6:0]     first_q;
   logic           sample;

   // Sample edge: the last of the SETTLE hold cycles for the current vector.
   assign sample = (state_q == SWEEP) && (cnt_q == SETTLE_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP:   if (sample && (x_q == 7'd127)) state_d = HOLD;
         HOLD:    if (tt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q     <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         mism_q  <= '0;
         first_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  exp_q   <= exp_tt;
                  tt_q    <= '0;
                  mism_q  <= '0;
                  first_q <= '0;
                  x_q     <= '0;
                  cnt_q   <= '0;
               end
            end
            SWEEP: begin
               if (sample) begin
                  tt_q[x_q] <= f_in;
                  if (f_in != exp_q[x_q]) begin
                     if (mism_q != MISM_MAX) mism_q <= mism_q + 8'd1;
                     if (mism_q == 8'd0) first_q <= x_q;
                  end
                  // 7-bit increment wraps 127 -> 0 as the sweep ends.
                  x_q   <= x_q + 7'd1;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign x          = x_q;
   assign busy       = (state_q != IDLE);
   assign tt_valid   = (state_q == HOLD);
   assign tt_out     = tt_q;
   assign mism_cnt   = mism_q;
   assign first_mism = first_q;
   assign mism_any   = (mism_q != 8'd0);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - self-checking bench for tt_sweep_capture
// Three instances (SETTLE = 1, 3, 4) share reset and exp_tt; a selector picks which one a test drives.
module tb_tt_sweep_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [127:0] exp_tt;
   logic         start1, start3, start4;
   logic         rdy1, rdy3, rdy4;
   logic         f1, f3, f4;
   logic [6:0]   x1, x3, x4;
   logic         busy1, busy3, busy4;
   logic [127:0] tt1, tt3, tt4;
   logic         v1, v3, v4;
   logic [7:0]   c1, c3, c4;
   logic [6:0]   fm1, fm3, fm4;
   logic         a1, a3, a4;

   int sel;
   int mode;
   int ph4;
   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [127:0] tt;
      logic [7:0]   cnt;
      logic [6:0]   first;
   } res_t;

   res_t sb[$];
   res_t last;

   tt_sweep_capture #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp_tt),
      .f_in(f1), .x(x1), .busy(busy1), .tt_out(tt1), .tt_valid(v1), .tt_ready(rdy1),
      .mism_cnt(c1), .first_mism(fm1), .mism_any(a1));
   tt_sweep_capture #(.SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(exp_tt),
      .f_in(f3), .x(x3), .busy(busy3), .tt_out(tt3), .tt_valid(v3), .tt_ready(rdy3),
      .mism_cnt(c3), .first_mism(fm3), .mism_any(a3));
   tt_sweep_capture #(.SETTLE(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .exp_tt(exp_tt),
      .f_in(f4), .x(x4), .busy(busy4), .tt_out(tt4), .tt_valid(v4), .tt_ready(rdy4),
      .mism_cnt(c4), .first_mism(fm4), .mism_any(a4));

   function automatic logic fgood(int m, logic [6:0] v);
      case (m)
         0:       return v[0];
         1:       return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
         2:       return 1'b1;
         3:       return v[0] ^ v[3];
         default: return (^v) ^ v[6];
      endcase
   endfunction

   // ph4 counts cycles since u4 accepted start; f4 is inverted on every non-sampling settle cycle.
   always @(posedge clk) begin
      if (start4 && !busy4) ph4 <= 0;
      else ph4 <= ph4 + 1;
   end

   assign f1 = fgood(mode, x1);
   assign f3 = fgood(mode, x3);
   assign f4 = ((ph4 % 4) == 3) ? fgood(mode, x4) : ~fgood(mode, x4);

   logic         o_valid, o_busy, o_any;
   logic [127:0] o_tt;
   logic [7:0]   o_cnt;
   logic [6:0]   o_first, o_x;

   always_comb begin
      o_valid = v1; o_busy = busy1; o_any = a1; o_tt = tt1; o_cnt = c1; o_first = fm1; o_x = x1;
      case (sel)
         3: begin o_valid = v3; o_busy = busy3; o_any = a3; o_tt = tt3; o_cnt = c3; o_first = fm3; o_x = x3; end
         4: begin o_valid = v4; o_busy = busy4; o_any = a4; o_tt = tt4; o_cnt = c4; o_first = fm4; o_x = x4; end
         default: ;
      endcase
   end

   task automatic set_start(logic v);
      start1 = (sel == 1) ? v : 1'b0;
      start3 = (sel == 3) ? v : 1'b0;
      start4 = (sel == 4) ? v : 1'b0;
   endtask

   task automatic set_ready(logic v);
      rdy1 = (sel == 1) ? v : 1'b0;
      rdy3 = (sel == 3) ? v : 1'b0;
      rdy4 = (sel == 4) ? v : 1'b0;
   endtask

   task automatic push_model(int m, logic [127:0] e);
      res_t r;
      r.tt = '0; r.cnt = '0; r.first = '0;
      for (int i = 0; i < 128; i++) begin
         r.tt[i] = fgood(m, 7'(i));
         if (r.tt[i] != e[i]) begin
            if (r.cnt == 8'd0) r.first = 7'(i);
            if (r.cnt != 8'd128) r.cnt = r.cnt + 8'd1;
         end
      end
      sb.push_back(r);
   endtask

   // Starts a sweep, scrambles exp_tt after acceptance, checks latency and result; leaves the DUT in HOLD.
   task automatic run_sweep(int s, int m, logic [127:0] e, int settle);
      int n;
      sel = s; mode = m; exp_tt = e;
      push_model(m, e);
      @(negedge clk); set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
      exp_tt = {$urandom, $urandom, $urandom, $urandom};
      total++; if (o_busy !== 1'b1) $display("FAIL busy_after_start sel=%0d got %b want 1", s, o_busy); else passed++;
      n = 0;
      while (!o_valid && n < 128 * settle + 50) begin
         @(posedge clk); #1 n++;
         if (n == 64 * settle && o_x !== 7'd64) $display("FAIL mid_sweep_x sel=%0d got %0d want 64", s, o_x);
      end
      total++; if (n !== 128 * settle) $display("FAIL latency sel=%0d got %0d want %0d", s, n, 128 * settle); else passed++;
      if (sb.size() == 0) begin
         total++; $display("FAIL scoreboard_empty sel=%0d", s);
      end else begin
         last = sb.pop_front();
         total++; if (o_tt !== last.tt) $display("FAIL tt_out sel=%0d got %h want %h", s, o_tt, last.tt); else passed++;
         total++; if (o_cnt !== last.cnt) $display("FAIL mism_cnt sel=%0d got %0d want %0d", s, o_cnt, last.cnt); else passed++;
         total++; if (o_first !== last.first) $display("FAIL first_mism sel=%0d got %0d want %0d", s, o_first, last.first); else passed++;
         total++; if (o_any !== (last.cnt != 8'd0)) $display("FAIL mism_any sel=%0d got %b want %b", s, o_any, last.cnt != 8'd0); else passed++;
         total++; if (o_x !== 7'd0) $display("FAIL x_wrap sel=%0d got %0d want 0", s, o_x); else passed++;
      end
   endtask

   task automatic release_hold();
      @(negedge clk); set_ready(1'b1);
      @(posedge clk); #1 set_ready(1'b0);
      total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) $display("FAIL release sel=%0d got valid=%b busy=%b want 0 0", sel, o_valid, o_busy); else passed++;
   endtask

   task automatic check_zero(string tag);
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_x !== 7'd0 || o_tt !== 128'd0 ||
          o_cnt !== 8'd0 || o_first !== 7'd0 || o_any !== 1'b0)
         $display("FAIL %s got valid=%b busy=%b x=%0d tt=%h cnt=%0d first=%0d any=%b want all zero",
                  tag, o_valid, o_busy, o_x, o_tt, o_cnt, o_first, o_any);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 1; s <= 4; s += (s == 1) ? 2 : 1) begin
         sel = s; check_zero("reset_state");
      end
      sel = 1;
      @(negedge clk); rst_n = 1'b1; set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
      total++; if (o_busy !== 1'b1) $display("FAIL first_start_accept got busy=%b want 1", o_busy); else passed++;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      check_zero("reset_abort_early");
   endtask

   task automatic test_basic();
      run_sweep(1, 0, {32{4'hA}}, 1);
      total++; if (o_tt !== {32{4'hA}} || o_cnt !== 8'd0 || o_any !== 1'b0)
         $display("FAIL basic_const got tt=%h cnt=%0d any=%b want aaaa.. 0 0", o_tt, o_cnt, o_any); else passed++;
      release_hold();
   endtask

   task automatic test_majority();
      run_sweep(1, 1, 128'd0, 1);
      total++; if (o_tt !== {16{8'hE8}} || o_cnt !== 8'd64 || o_first !== 7'd3 || o_any !== 1'b1)
         $display("FAIL majority_const got tt=%h cnt=%0d first=%0d any=%b want e8e8.. 64 3 1", o_tt, o_cnt, o_first, o_any); else passed++;
      release_hold();
   endtask

   task automatic test_settle3_saturate();
      run_sweep(3, 2, 128'd0, 3);
      total++; if (o_tt !== {128{1'b1}} || o_cnt !== 8'd128 || o_first !== 7'd0)
         $display("FAIL all_mism_const got tt=%h cnt=%0d first=%0d want ones 128 0", o_tt, o_cnt, o_first); else passed++;
      release_hold();
   endtask

   task automatic test_hold();
      int bad;
      run_sweep(1, 3, {$urandom, $urandom, $urandom, $urandom}, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); set_start(i[0]);
         @(posedge clk); #1;
         if (o_valid !== 1'b1 || o_tt !== last.tt || o_cnt !== last.cnt || o_first !== last.first) bad++;
      end
      total++; if (bad != 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else passed++;
      @(negedge clk); set_start(1'b1); set_ready(1'b1);
      @(posedge clk); #1 set_ready(1'b0);
      total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) $display("FAIL handshake_start got busy=%b valid=%b want 0 0", o_busy, o_valid); else passed++;
      total++; if (o_tt !== last.tt || o_cnt !== last.cnt || o_first !== last.first)
         $display("FAIL idle_retain got tt=%h cnt=%0d want tt=%h cnt=%0d", o_tt, o_cnt, last.tt, last.cnt); else passed++;
      @(negedge clk); set_start(1'b0);
   endtask

   task automatic test_reset_mid();
      int n;
      int seen;
      sel = 1; mode = 4;
      @(negedge clk); set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
      n = 0;
      while (o_x !== 7'd50 && n < 200) begin @(posedge clk); #1 n++; end
      total++; if (o_x !== 7'd50) $display("FAIL reach_x50 got %0d want 50", o_x); else passed++;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      check_zero("reset_mid_sweep");
      seen = 0;
      repeat (200) begin @(posedge clk); #1 if (o_valid) seen++; end
      total++; if (seen != 0) $display("FAIL no_valid_after_abort got %0d valid cycles want 0", seen); else passed++;
      run_sweep(1, 4, {$urandom, $urandom, $urandom, $urandom}, 1);
      release_hold();
   endtask

   task automatic test_toggle();
      run_sweep(4, 3, {$urandom, $urandom, $urandom, $urandom}, 4);
      release_hold();
   endtask

   task automatic test_back_to_back();
      run_sweep(1, 0, 128'd0, 1);
      release_hold();
      run_sweep(1, 1, {16{8'hE8}}, 1);
      total++; if (o_cnt !== 8'd0 || o_any !== 1'b0) $display("FAIL b2b_clear got cnt=%0d any=%b want 0 0", o_cnt, o_any); else passed++;
      release_hold();
   endtask

   initial begin
      rst_n = 1'b0; exp_tt = '0; sel = 1; mode = 0;
      start1 = 1'b0; start3 = 1'b0; start4 = 1'b0;
      rdy1 = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0;
      test_reset();
      test_basic();
      test_majority();
      test_settle3_saturate();
      test_hold();
      test_reset_mid();
      test_toggle();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles each input vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  pulse; begins a sweep when accepted.
REQ-005 exp_tt  input  128  expected truth table; latched at start acceptance.
REQ-006 f_in  input  1  output of the external combinational 7-input function under test.
REQ-007 x  output  7  input vector driven to the function under test; x[0] is LSB.
REQ-008 busy  output  1  high while a sweep is in progress or a result is pending.
REQ-009 tt_out  output  128  captured truth table; bit i = f(x=i).
REQ-010 tt_valid  output  1  result available.
REQ-011 tt_ready  input  1  consumer accepts result.
REQ-012 mism_cnt  output  8  number of bit positions where tt_out differs from exp_tt (0..128).
REQ-013 first_mism  output  7  lowest index with a mismatch; 0 when mism_cnt = 0.
REQ-014 mism_any  output  1  high when mism_cnt != 0; valid with tt_valid.

Function
REQ-015 The block SHALL use three states: IDLE, SWEEP, HOLD.
REQ-016 In IDLE, start = 1 SHALL latch exp_tt, clear tt_out, mism_cnt, first_mism, set x = 0, clear the settle counter and enter SWEEP on the next edge.
REQ-017 In SWEEP, x SHALL be held for SETTLE cycles; on the edge ending the last hold cycle, tt_out[x] SHALL take the f_in value present in that cycle.
REQ-018 On the same edge, if f_in != exp_tt[x], mism_cnt SHALL increment, and first_mism SHALL take x if this is the first mismatch of the sweep.
REQ-019 After sampling, x SHALL advance by 1; after sampling x = 127, the block SHALL enter HOLD and x SHALL wrap to 0.
REQ-020 A sweep SHALL take exactly 128*SETTLE cycles from entering SWEEP to entering HOLD.
REQ-021 tt_valid SHALL be 1 exactly while in HOLD; tt_out, mism_cnt, first_mism and mism_any SHALL be stable while tt_valid = 1.
REQ-022 In HOLD, tt_valid && tt_ready SHALL return the block to IDLE on that edge; outputs SHALL keep their values until the next accepted start.
REQ-023 busy SHALL be 1 in SWEEP and HOLD, 0 in IDLE.
REQ-024 start SHALL be ignored in SWEEP and HOLD, including the handshake cycle of HOLD; a new sweep requires start in IDLE.
REQ-025 mism_cnt SHALL saturate at 128 and never wrap; 128 is reachable when every bit mismatches.
REQ-026 exp_tt changes after start acceptance SHALL NOT affect the running sweep.
REQ-027 f_in SHALL be sampled only on the sample edge of each vector; values in earlier settle cycles SHALL be ignored.

Reset
REQ-028 On a clk edge with rst_n = 0, the block SHALL enter IDLE with x = 0, tt_out = 0, tt_valid = 0, busy = 0, mism_cnt = 0, first_mism = 0, mism_any = 0 and settle counter = 0.
REQ-029 Reset asserted mid-SWEEP or in HOLD SHALL abort the sweep and discard partial results with no tt_valid pulse.
REQ-030 The first start SHALL be accepted on the first edge after rst_n is high.

Verification
REQ-031 SETTLE=1, f_in = x[0], exp_tt = 0xAAAA...AAAA, start -> tt_valid after 128 SWEEP cycles, tt_out = 0xAAAA...AAAA, mism_cnt = 0, mism_any = 0.
REQ-032 f_in = majority(x[0],x[1],x[2]), exp_tt = 0 -> tt_out = 0xE8E8...E8E8, mism_cnt = 64, first_mism = 3.
REQ-033 f_in = 1, exp_tt = 0, SETTLE=3 -> tt_valid exactly 384 cycles after entering SWEEP, tt_out = all ones, mism_cnt = 128.
REQ-034 tt_ready held low 20 cycles in HOLD, start pulsed during HOLD -> outputs stable, start ignored; tt_ready = 1 -> IDLE next edge.
REQ-035 rst_n low at x = 50 -> next edge IDLE, all outputs 0, no tt_valid; a following sweep produces a correct table.
REQ-036 f_in toggled during the non-sampling settle cycles with SETTLE=4 -> tt_out reflects only the sample-edge values.
